result_display_reader: RTL and testbench
========================================

RESULT_DISPLAY_READER -- requirements
Module: result_display_reader

Interface
REQ-001 SCAN_DIV, default 4: clock cycles each display digit is held; legal range 2..65535.
REQ-002 clk  input  1  system clock; every flop is rising-edge triggered.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 read  input  1  user pop request, asynchronous to clk, level or pulse.
REQ-005 lifo_empty  input  1  high when the result LIFO holds no entries.
REQ-006 lifo_data  input  9  top LIFO entry as {opcode[2:0], result[5:0]}; valid one cycle after lifo_pop.
REQ-007 lifo_pop  output  1  one-cycle pop strobe to the LIFO.
REQ-008 display  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.
REQ-009 displayctl  output  4  active-low digit enables; exactly one bit low at any time.

Function
REQ-010 read passes through a 2-flop synchronizer, then a rising-edge detector (third flop); a rise produces a one-cycle rd_evt.
REQ-011 The FSM has states IDLE, POP, CAPTURE.
REQ-012 IDLE with rd_evt and lifo_empty=0: go to POP; lifo_pop=1 for exactly that one cycle.
REQ-013 POP always goes to CAPTURE. In CAPTURE, {op_q,res_q} <= lifo_data, show <= VALID, then go to IDLE.
REQ-014 IDLE with rd_evt and lifo_empty=1: lifo_pop stays 0, show <= EMPTY_ERR, stay in IDLE; op_q and res_q are kept.
REQ-015 rd_evt in POP or CAPTURE is dropped and is not queued.
REQ-016 Latency: read high before clk edge k gives lifo_pop=1 in the cycle following edge k+3. Captured data reaches display no later than the next scan of each digit.
REQ-017 A read held high gives exactly one pop; a new pop requires read to go low for at least 2 cycles and then rise again.
REQ-018 A scan counter counts 0..SCAN_DIV-1. On wrap, digit index 0..3 increments modulo 4 (3 wraps to 0).
REQ-019 displayctl = ~(4'b0001 << idx).
REQ-020 show=NONE: all digits dash (8'hBF).
REQ-021 show=VALID: d3=hex(op_q), d2=blank (8'hFF), d1=hex({2'b00,res_q[5:4]}), d0=hex(res_q[3:0]).
REQ-022 show=EMPTY_ERR: d3='E' (8'h86), d2..d0=dash.
REQ-023 Hex codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-024 A successful CAPTURE clears EMPTY_ERR.
REQ-025 lifo_empty is sampled only in IDLE at rd_evt; it is ignored in POP and CAPTURE.
REQ-026 display and displayctl are registered, so they change only on clk edges.

Reset
REQ-027 Asserting reset_n=0 immediately clears: FSM=IDLE, lifo_pop=0, synchronizer and edge flops=0, scan counter=0, idx=0, show=NONE, op_q=0, res_q=0, displayctl=4'b1110, display=8'hBF.
REQ-028 Reset asserted in POP or CAPTURE aborts the read with no capture; after release, the next rd_evt requires a fresh read rise.

Structure
REQ-029 A shared package holds: the show enum (NONE, VALID, EMPTY_ERR), the FSM state enum, field widths OP_W=3 and RES_W=6, and the segment constants SEG_BLANK, SEG_DASH, SEG_E.
REQ-030 The hex-to-segment decode is one combinational sub-module, hex_to_seg7 (4-bit input, 8-bit active-low output, dp=1); the design instantiates it once on the muxed nibble.

Verification
REQ-031 Reset: reset_n=0 held 10 cycles -> lifo_pop=0, displayctl=1110, display=BF throughout.
REQ-032 Pop: lifo_empty=0, lifo_data=9'b101_101101, read rises -> one lifo_pop pulse 3 cycles later; scan then shows d3=92, d2=FF, d1=A4, d0=A1.
REQ-033 Empty: lifo_empty=1, read rises -> lifo_pop never asserts; d3=86, d2..d0=BF. A later non-empty pop restores VALID.
REQ-034 Hold and collision: read high for 20 cycles -> exactly one pop. Two read rises 2 cycles apart -> one pop.
REQ-035 Scan: SCAN_DIV=4 -> displayctl sequence 1110, 1101, 1011, 0111, 1110, each value held 4 cycles.
REQ-036 Reset mid-op: reset_n=0 in the cycle lifo_pop=1 -> lifo_pop drops at once, display returns to dashes, op_q and res_q are not updated.

Source files
------------

// File: rtl/result_display_reader_pkg.sv
// Shared types and constants for the LIFO result reader and its 4-digit scanned display.
package result_display_reader_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 6;
  localparam int unsigned LIFO_W = OP_W + RES_W;
  localparam int unsigned SCAN_W = 16;
  localparam int unsigned SEG_W  = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h86;

  typedef enum logic [1:0] {
    SHOW_NONE      = 2'd0,
    SHOW_VALID     = 2'd1,
    SHOW_EMPTY_ERR = 2'd2
  } show_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [RES_W-1:0] res;
  } lifo_entry_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decode, decimal point held off.
module hex_to_seg7 (
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    case (nib_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/result_display_reader.sv
// Pops one LIFO entry per user read rise and shows opcode/result on a scanned 4-digit display.
module result_display_reader
  import result_display_reader_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read,
  input  logic              lifo_empty,
  input  logic [LIFO_W-1:0] lifo_data,
  output logic              lifo_pop,
  output logic [SEG_W-1:0]  display,
  output logic [3:0]        displayctl
);

  state_e            state_q, state_d;
  show_e             show_q, show_d;
  lifo_entry_t       entry_q, entry_d;
  logic              pop_q, pop_d;
  logic [2:0]        sync_q;
  logic              rd_evt_q;
  logic [SCAN_W-1:0] cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        nib_c;
  logic [SEG_W-1:0]  hex_seg_c;
  logic [SEG_W-1:0]  seg_d;
  logic [SEG_W-1:0]  display_q;
  logic [3:0]        displayctl_q;

  // Synchronize read, then register the rise so it arrives as a clean one-cycle event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      rd_evt_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], read};
      rd_evt_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    show_d  = show_q;
    entry_d = entry_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_evt_q) begin
          if (!lifo_empty) begin
            state_d = ST_POP;
            pop_d   = 1'b1;
          end else begin
            show_d = SHOW_EMPTY_ERR;
          end
        end
      end
      ST_POP:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        entry_d = lifo_entry_t'(lifo_data);
        show_d  = SHOW_VALID;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_q   <= 1'b0;
      show_q  <= SHOW_NONE;
      entry_q <= '0;
    end else begin
      pop_q   <= pop_d;
      show_q  <= show_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q + SCAN_W'(1);
    idx_d = idx_q;
    if (cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Digit 3 carries the opcode, digits 1..0 the result split as 2+4 bits.
  always_comb begin
    case (idx_q)
      2'd3:    nib_c = {1'b0, entry_q.op};
      2'd1:    nib_c = {2'b00, entry_q.res[5:4]};
      2'd0:    nib_c = entry_q.res[3:0];
      default: nib_c = 4'h0;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (nib_c),
    .seg_o (hex_seg_c)
  );

  always_comb begin
    seg_d = SEG_DASH;
    case (show_q)
      SHOW_VALID:     seg_d = (idx_q == 2'd2) ? SEG_BLANK : hex_seg_c;
      SHOW_EMPTY_ERR: seg_d = (idx_q == 2'd3) ? SEG_E : SEG_DASH;
      default:        seg_d = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      display_q    <= SEG_DASH;
      displayctl_q <= 4'b1110;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      display_q    <= seg_d;
      displayctl_q <= ~(4'b0001 << idx_q);
    end
  end

  assign lifo_pop   = pop_q;
  assign display    = display_q;
  assign displayctl = displayctl_q;

endmodule

// File: tb/tb_result_display_reader.sv
// Randomized self-checking bench for result_display_reader with a LIFO and display reference model.
module tb_result_display_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       read = 1'b0;
  logic       lifo_empty = 1'b1;
  logic [8:0] lifo_data = '0;
  logic       lifo_pop;
  logic [7:0] display;
  logic [3:0] displayctl;

  int n_pass = 0;
  int n_total = 0;
  int pop_cnt = 0;

  logic [8:0] stk[$];
  int         m_show = 0;
  logic [2:0] m_op = '0;
  logic [5:0] m_res = '0;
  logic [7:0] obs[4];
  logic [7:0] hex_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  result_display_reader #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read       (read),
    .lifo_empty (lifo_empty),
    .lifo_data  (lifo_data),
    .lifo_pop   (lifo_pop),
    .display    (display),
    .displayctl (displayctl)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and let the LIFO model answer any pop strobe.
  task automatic tick();
    @(negedge clk);
    if (reset_n && lifo_pop === 1'b1) begin
      pop_cnt++;
      if (stk.size() > 0) lifo_data = stk.pop_back();
      lifo_empty = (stk.size() == 0);
    end
  endtask

  task automatic push(input logic [8:0] e);
    stk.push_back(e);
    lifo_empty = 1'b0;
  endtask

  task automatic do_read(input int hold);
    tick();
    read = 1'b1;
    repeat (hold) tick();
    read = 1'b0;
    repeat (10) tick();
  endtask

  task automatic grab();
    logic [3:0] m;
    for (int d = 0; d < 4; d++) obs[d] = 8'h00;
    repeat (20) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        m = 4'b0001 << d;
        if (displayctl === ~m) obs[d] = display;
      end
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [3:0] n;
    case (m_show)
      1: begin
        if (d == 3)      n = {1'b0, m_op};
        else if (d == 1) n = 4'(m_res / 16);
        else             n = 4'(m_res % 16);
        return (d == 2) ? 8'hFF : hex_tab[n];
      end
      2:       return (d == 3) ? 8'h86 : 8'hBF;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_total++;
      if (lifo_pop !== 1'b0) $display("FAIL reset_pop cyc=%0d got=%b exp=0", c, lifo_pop);
      else n_pass++;
      n_total++;
      if (displayctl !== 4'b1110) $display("FAIL reset_ctl cyc=%0d got=%b exp=1110", c, displayctl);
      else n_pass++;
      n_total++;
      if (display !== 8'hBF) $display("FAIL reset_disp cyc=%0d got=%h exp=BF", c, display);
      else n_pass++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] prev, m;
    bit found = 0;
    prev = displayctl;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (prev !== 4'b1110 && displayctl === 4'b1110) found = 1;
      else prev = displayctl;
    end
    n_total++;
    if (!found) $display("FAIL scan_sync timeout got=%b exp=1110", displayctl);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      m = 4'b0001 << ((i / 4) % 4);
      n_total++;
      if (displayctl !== ~m) $display("FAIL scan_seq i=%0d got=%b exp=%b", i, displayctl, ~m);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_pop();
    int pb;
    logic [7:0] lit[4];
    lit = '{8'hA1, 8'hA4, 8'hFF, 8'h92};
    push(9'b101_101101);
    pb = pop_cnt;
    tick();
    read = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      n_total++;
      if (lifo_pop !== (e == 3)) $display("FAIL pop_latency cyc=%0d got=%b exp=%b", e, lifo_pop, (e == 3));
      else n_pass++;
    end
    read = 1'b0;
    repeat (10) tick();
    m_show = 1; m_op = 3'b101; m_res = 6'b101101;
    n_total++;
    if (pop_cnt - pb != 1) $display("FAIL pop_count got=%0d exp=1", pop_cnt - pb);
    else n_pass++;
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== lit[d]) $display("FAIL pop_digit d%0d got=%h exp=%h", d, obs[d], lit[d]);
      else n_pass++;
    end
  endtask

  task automatic test_empty();
    int pb;
    logic [8:0] e;
    stk = {};
    lifo_empty = 1'b1;
    pb = pop_cnt;
    do_read(3);
    m_show = 2;
    n_total++;
    if (pop_cnt - pb != 0) $display("FAIL empty_nopop got=%0d exp=0", pop_cnt - pb);
    else n_pass++;
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== ((d == 3) ? 8'h86 : 8'hBF)) $display("FAIL empty_digit d%0d got=%h exp=%h", d, obs[d], (d == 3) ? 8'h86 : 8'hBF);
      else n_pass++;
    end
    e = 9'($urandom);
    push(e);
    do_read(2);
    m_show = 1; m_op = e[8:6]; m_res = e[5:0];
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== exp_seg(d)) $display("FAIL empty_recover d%0d got=%h exp=%h", d, obs[d], exp_seg(d));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int pb;
    logic [8:0] a, b;
    stk = {};
    a = 9'($urandom); b = 9'($urandom);
    push(a); push(b);
    pb = pop_cnt;
    do_read(20);
    m_show = 1; m_op = b[8:6]; m_res = b[5:0];
    n_total++;
    if (pop_cnt - pb != 1) $display("FAIL hold_count got=%0d exp=1", pop_cnt - pb);
    else n_pass++;
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== exp_seg(d)) $display("FAIL hold_digit d%0d got=%h exp=%h", d, obs[d], exp_seg(d));
      else n_pass++;
    end
    pb = pop_cnt;
    tick(); read = 1'b1;
    tick(); read = 1'b0;
    tick(); read = 1'b1;
    repeat (5) tick();
    read = 1'b0;
    repeat (10) tick();
    m_op = a[8:6]; m_res = a[5:0];
    n_total++;
    if (pop_cnt - pb != 1) $display("FAIL collide_count got=%0d exp=1", pop_cnt - pb);
    else n_pass++;
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== exp_seg(d)) $display("FAIL collide_digit d%0d got=%h exp=%h", d, obs[d], exp_seg(d));
      else n_pass++;
    end
  endtask

  task automatic test_random(input int iters);
    int pb, ep, hold, n;
    logic [8:0] e;
    for (int it = 0; it < iters; it++) begin
      n = $urandom_range(0, 2);
      repeat (n) push(9'($urandom));
      hold = $urandom_range(1, 20);
      pb = pop_cnt;
      if (stk.size() > 0) begin
        e = stk[$];
        m_show = 1; m_op = e[8:6]; m_res = e[5:0]; ep = 1;
      end else begin
        m_show = 2; ep = 0;
      end
      do_read(hold);
      n_total++;
      if (pop_cnt - pb != ep) $display("FAIL rand_pop it=%0d got=%0d exp=%0d", it, pop_cnt - pb, ep);
      else n_pass++;
      grab();
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (obs[d] !== exp_seg(d)) $display("FAIL rand_digit it=%0d d%0d got=%h exp=%h", it, d, obs[d], exp_seg(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int pb;
    bit found = 0;
    push(9'($urandom));
    pb = pop_cnt;
    tick();
    read = 1'b1;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (lifo_pop === 1'b1) found = 1;
    end
    n_total++;
    if (!found) $display("FAIL midrst_wait timeout got=%b exp=1", lifo_pop);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (lifo_pop !== 1'b0) $display("FAIL midrst_pop got=%b exp=0", lifo_pop);
    else n_pass++;
    n_total++;
    if (display !== 8'hBF) $display("FAIL midrst_disp got=%h exp=BF", display);
    else n_pass++;
    n_total++;
    if (displayctl !== 4'b1110) $display("FAIL midrst_ctl got=%b exp=1110", displayctl);
    else n_pass++;
    read = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    m_show = 0; m_op = '0; m_res = '0;
    repeat (12) tick();
    n_total++;
    if (pop_cnt - pb != 1) $display("FAIL midrst_count got=%0d exp=1", pop_cnt - pb);
    else n_pass++;
    grab();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs[d] !== exp_seg(d)) $display("FAIL midrst_digit d%0d got=%h exp=%h", d, obs[d], exp_seg(d));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pop();
    test_empty();
    test_back_to_back();
    test_random(10);
    test_reset_mid();
    test_random(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
